// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - default WIDTH / INC_STEP / RAS_DEPTH values
//   - action_e: the single action taken on a clock edge, used by the
//     pc_unit priority decode and by the testbench scoreboard.
package pc_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_INC_STEP  = 1;
  localparam int DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    BRANCH,
    CALL,
    RET
  } action_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack, a circular LIFO.
//   A push onto a full stack overwrites the oldest entry and keeps the
//   count at DEPTH; a pop from an empty stack changes nothing. Both events
//   set sticky flags that clear only on clr. Only built when the pc_unit
//   is compiled with PC_RAS_EN.
// Ports:
//   clk, clr          rising-edge clock, synchronous active-high reset
//   push, pop         one-hot requests (never both in the same cycle)
//   push_data         value written on push
//   top               most recently pushed entry
//   empty, full       decoded from the registered entry count
//   overflow          sticky: push while full
//   underflow         sticky: pop while empty
module pc_ras #(
  parameter int WIDTH = pc_pkg::DEF_WIDTH,
  parameter int DEPTH = pc_pkg::DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;   // next slot to write; wraps, so it also marks the oldest entry when full
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign rd_ptr = wr_ptr - PTR_ONE;
  assign top    = mem[rd_ptr];
  assign empty  = (count == '0);
  assign full   = (count == CNT_MAX);

  // NOTE: storage has no reset; the count alone says which entries are valid,
  // so clearing the array would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (full) overflow <= 1'b1;
      else      count    <= count + CNT_ONE;
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        wr_ptr <= rd_ptr;
        count  <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter with stall, branch load and an
//   optional return-address stack.
//   One action per edge, priority: clr > stall > ret > IncPC > con_out.
//   Build option: define PC_RAS_EN to build the RAS and honour call/ret;
//   without it call/ret are ignored and the RAS outputs are constants.
// Ports:
//   clk, clr          rising-edge clock, synchronous active-high reset
//   PC_enable         0 stalls every state update
//   IncPC             advance by INC_STEP
//   con_out, MuxOut   branch-taken condition and target
//   call, ret         push return address on a taken branch / pop into PC
//   PC_data_out       registered PC
//   ras_empty, ras_full, ras_overflow, ras_underflow   RAS status
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               INC_STEP  = DEF_INC_STEP,
  parameter int               RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             PC_enable,
  input  logic             IncPC,
  input  logic             con_out,
  input  logic [WIDTH-1:0] MuxOut,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] PC_data_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             call_req;
  logic             ret_req;
  action_e          act;

  assign pc_inc      = pc + STEP;   // wraps modulo 2^WIDTH
  assign PC_data_out = pc;

`ifdef PC_RAS_EN
  assign call_req = call;
  assign ret_req  = ret;

  // Push happens on the same edge as the branch load, so the saved
  // address is the pre-edge PC + INC_STEP.
  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .clr       (clr),
    .push      (act == CALL),
    .pop       (act == RET),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = call ^ ret;
  assign call_req      = 1'b0;
  assign ret_req       = 1'b0;
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  // Priority decode. clr is folded in so the RAS sees no push/pop on a
  // reset edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    act = HOLD;
    if (clr || !PC_enable) act = HOLD;
    else if (ret_req)      act = RET;
    else if (IncPC)        act = INC;
    else if (con_out)      act = call_req ? CALL : BRANCH;
  end

  always_comb begin
    pc_next = pc;
    case (act)
      INC:         pc_next = pc_inc;
      BRANCH,
      CALL:        pc_next = MuxOut;
      RET:         pc_next = ras_empty ? pc_inc : ras_top;
      default:     pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) pc <= RESET_VAL;
    else     pc <= pc_next;
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, self-checking bench for pc_unit (WIDTH=8,
// RESET_VAL=0x10, INC_STEP=1, RAS_DEPTH=4). Each step drives one cycle of
// inputs, a reference model computes the expected PC and RAS status into
// a scoreboard queue, and the entry is popped and compared #1 after the
// edge. Literal checks from the test plan are added on top. Works with
// and without PC_RAS_EN.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int         W     = 8;
  localparam logic [7:0] RST   = 8'h10;
  localparam int         DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         PC_enable = 1'b0;
  logic         IncPC = 1'b0;
  logic         con_out = 1'b0;
  logic [W-1:0] MuxOut = '0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic [W-1:0] PC_data_out;
  logic         ras_empty, ras_full, ras_overflow, ras_underflow;

  pc_unit #(
    .WIDTH     (W),
    .RESET_VAL (RST),
    .INC_STEP  (1),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .PC_enable     (PC_enable),
    .IncPC         (IncPC),
    .con_out       (con_out),
    .MuxOut        (MuxOut),
    .call          (call),
    .ret           (ret),
    .PC_data_out   (PC_data_out),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    action_e    act;
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_ras[$];
  logic [7:0] m_pc = RST;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, model, push expectation, wait, pop and compare.
  task automatic step(input string tag, input logic c, input logic en, input logic inc,
                      input logic co, input logic ca, input logic rt, input logic [7:0] mux);
    action_e    act;
    exp_t       e;
    logic [7:0] nxt;
    clr = c; PC_enable = en; IncPC = inc; con_out = co; call = ca; ret = rt; MuxOut = mux;

    act = HOLD;
    if (c) begin
      m_pc = RST;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (!en)              act = HOLD;
      else if (rt && RAS_ON) act = RET;
      else if (inc)          act = INC;
      else if (co)           act = (ca && RAS_ON) ? CALL : BRANCH;
      nxt = m_pc + 8'd1;
      case (act)
        INC:    m_pc = nxt;
        BRANCH: m_pc = mux;
        CALL: begin
          m_ras.push_back(nxt);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = mux;
        end
        RET: begin
          if (m_ras.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = nxt;
          end else begin
            m_pc = m_ras.pop_back();
          end
        end
        default: ;
      endcase
    end

    e.tag   = tag;
    e.act   = act;
    e.pc    = m_pc;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "/", e.act.name(), " pc"},        PC_data_out,   e.pc);
    check({e.tag, "/", e.act.name(), " empty"},     ras_empty,     e.empty);
    check({e.tag, "/", e.act.name(), " full"},      ras_full,      e.full);
    check({e.tag, "/", e.act.name(), " overflow"},  ras_overflow,  e.ovf);
    check({e.tag, "/", e.act.name(), " underflow"}, ras_underflow, e.unf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and sequential advance
    step("reset", 1, 0, 0, 0, 0, 0, 8'h00);
    check("reset pc literal", PC_data_out, 8'h10);
    check("reset empty literal", ras_empty, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      step("inc", 0, 1, 1, 0, 0, 0, 8'h00);
      check($sformatf("inc%0d literal", i), PC_data_out, 8'h10 + 8'(i));
    end

    // Stall, branch, hold
    step("br20", 0, 1, 0, 1, 0, 0, 8'h20);
    step("stall_inc", 0, 0, 1, 0, 0, 0, 8'h00);
    check("stall literal", PC_data_out, 8'h20);
    step("br80", 0, 1, 0, 1, 0, 0, 8'h80);
    check("branch literal", PC_data_out, 8'h80);
    step("hold", 0, 1, 0, 0, 0, 0, 8'h55);
    check("hold literal", PC_data_out, 8'h80);

    // clr overrides every concurrent request
    step("clr_mid", 1, 1, 1, 1, 1, 1, 8'h77);
    check("clr_mid literal", PC_data_out, 8'h10);

    // Call then immediate return
    step("br40", 0, 1, 0, 1, 0, 0, 8'h40);
    step("call", 0, 1, 0, 1, 1, 0, 8'hA0);
    check("call pc literal", PC_data_out, 8'hA0);
    step("ret", 0, 1, 0, 0, 0, 1, 8'h00);
`ifdef PC_RAS_EN
    check("ret pc literal", PC_data_out, 8'h41);
`else
    check("ret ignored literal", PC_data_out, 8'hA0);
`endif

    // Five nested calls into a 4-deep stack, then five returns
    step("br01", 0, 1, 0, 1, 0, 0, 8'h01);
    for (int i = 1; i <= 5; i++)
      step($sformatf("call_n%0d", i), 0, 1, 0, 1, 1, 0, 8'(i + 1));
`ifdef PC_RAS_EN
    check("nested full literal", ras_full, 1'b1);
    check("nested overflow literal", ras_overflow, 1'b1);
`endif
    for (int i = 0; i < 4; i++) begin
      step($sformatf("ret_n%0d", i), 0, 1, 0, 0, 0, 1, 8'h00);
`ifdef PC_RAS_EN
      check($sformatf("ret_n%0d literal", i), PC_data_out, 8'h06 - 8'(i));
`endif
    end
    step("ret_under", 0, 1, 0, 0, 0, 1, 8'h00);
`ifdef PC_RAS_EN
    check("underflow pc literal", PC_data_out, 8'h04);
    check("underflow flag literal", ras_underflow, 1'b1);
`endif

    // Stalled call/ret leaves everything alone
    step("stall_ret", 0, 0, 0, 1, 1, 1, 8'h33);

    // ret beats IncPC and con_out
    step("call2", 0, 1, 0, 1, 1, 0, 8'h50);
    step("prio", 0, 1, 1, 1, 1, 1, 8'h99);
`ifdef PC_RAS_EN
    check("prio ret literal", PC_data_out, 8'h05);
`else
    check("prio inc literal", PC_data_out, 8'h51);
`endif

    // call without a taken branch, or alongside IncPC, never pushes
    step("call_nocon", 0, 1, 0, 0, 1, 0, 8'h66);
    step("call_inc", 0, 1, 1, 1, 1, 0, 8'h66);
    check("no push literal", ras_empty, 1'b1);

    // Modulo wrap
    step("brFF", 0, 1, 0, 1, 0, 0, 8'hFF);
    step("wrap", 0, 1, 1, 0, 0, 0, 8'h00);
    check("wrap literal", PC_data_out, 8'h00);

    // Sticky flags clear only on clr
    step("clr_end", 1, 0, 0, 0, 0, 0, 8'h00);
    check("clr_end ovf literal", ras_overflow, 1'b0);
    check("clr_end unf literal", ras_underflow, 1'b0);

    check("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the datapath, the next generation of the single-register PC. Adds configurable width, reset vector and increment step, a stall/enable gate, conditional branch load and an optional return-address stack (RAS) for call/return. It sits between the bus multiplexer (`MuxOut`), the control unit (`IncPC`, `PC_enable`, `call`, `ret`) and the condition logic (`con_out`), and drives instruction-fetch addressing.

## Interface
- `WIDTH`, 32, PC and target width in bits.
- `RESET_VAL`, 0, PC value after reset.
- `INC_STEP`, 1, amount added on sequential advance.
- `RAS_DEPTH`, 4, RAS entries; power of two, ≥ 2.

- `clk` in 1: rising-edge clock.
- `clr` in 1: synchronous, active-high reset.
- `PC_enable` in 1: gates every state update; 0 means stall.
- `IncPC` in 1: sequential advance request.
- `con_out` in 1: branch-taken condition from the condition logic.
- `MuxOut` in WIDTH: branch/jump target.
- `call` in 1: with a taken branch, push the return address.
- `ret` in 1: pop the return address into the PC.
- `PC_data_out` out WIDTH: current PC (registered).
- `ras_empty` out 1: RAS holds 0 entries.
- `ras_full` out 1: RAS holds RAS_DEPTH entries.
- `ras_overflow` out 1: sticky; a push occurred while the RAS was full.
- `ras_underflow` out 1: sticky; a pop occurred while the RAS was empty.

## Operation
- One action per edge. Priority: `clr` > (`PC_enable`=0: hold all) > `ret` > `IncPC` > `con_out`.
- `ret`=1 with RAS non-empty: PC ← top entry; pop.
- `ret`=1 with RAS empty: PC ← PC+INC_STEP; set `ras_underflow`.
- `IncPC`=1: PC ← PC+INC_STEP. `call` and `con_out` are ignored.
- `con_out`=1: PC ← MuxOut. If `call`=1, also push PC+INC_STEP.
- Push while full: the RAS is a circular buffer, so the oldest entry is overwritten and the count stays at RAS_DEPTH. Set `ras_overflow`.
- `call` without `con_out`, or with `IncPC`: no push.
- No request asserted: hold.
- Arithmetic is modulo 2^WIDTH. PC = 2^WIDTH−1 with INC_STEP=1 wraps to 0.
- Sticky flags clear only on `clr`.
- Entry counter is clog2(RAS_DEPTH)+1 bits. `ras_empty`/`ras_full` are decoded from the registered count.

## Timing
- Reset values (one edge with `clr`=1): PC_data_out=RESET_VAL, count=0, ras_empty=1, ras_full=0, both sticky flags=0. RAS contents need not be cleared.
- `clr` mid-operation overrides any concurrent request in that cycle.
- Latency: inputs are sampled at edge N. PC_data_out and the flags reflect the result after edge N, with no combinational path from inputs to outputs.
- Push and PC load happen on the same edge, so the pushed value is the pre-edge PC+INC_STEP.
- Back-to-back call→ret on consecutive enabled cycles returns exactly the pushed address.
- Stalled cycles (`PC_enable`=0) leave the PC, RAS pointer, count and flags unchanged, even if `ret` or `call` is asserted.

## Configuration
- Macro: `PC_RAS_EN`.
- Defined: RAS, `call`/`ret` behaviour and all four RAS outputs as above.
- Undefined: no RAS storage or counters are built.
  - `call` and `ret` are ignored, so priority becomes `IncPC` > `con_out`.
  - Outputs are tied: ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0.
- Base PC behaviour is identical in both builds.

## Structure
- Shared package `pc_pkg`:
  - default WIDTH/INC_STEP/RAS_DEPTH constants;
  - an action enum {HOLD, INC, BRANCH, CALL, RET} used by both the RTL decode and the bench scoreboard.
- One sub-module, `pc_ras`: circular LIFO with push/pop, top, count, full/empty and overflow/underflow detect, parametrised on WIDTH and RAS_DEPTH. Instantiated only under `PC_RAS_EN`.
- Priority decode and PC register stay in `pc_unit`.

## Test plan
- Reset/increment: RESET_VAL=0x10, clr for 1 cycle, then IncPC+PC_enable for 3 cycles → PC=0x10, 0x11, 0x12, 0x13.
- Stall and branch:
  - PC=0x20, PC_enable=0 with IncPC=1 → PC stays 0x20.
  - Then con_out=1, MuxOut=0x80 → PC=0x80.
  - con_out=0 with no IncPC → PC holds.
- Call/return: PC=0x40, call+con_out, MuxOut=0x100 → PC=0x100, ras_empty=0; next cycle ret → PC=0x41, ras_empty=1.
- Overflow: RAS_DEPTH=4, 5 nested calls from PCs 0x1..0x5 → ras_full=1, ras_overflow=1. Four rets yield 0x6, 0x5, 0x4, 0x3; a 5th ret sets ras_underflow and gives PC+1.
- Wrap and priority:
  - WIDTH=8, PC=0xFF, IncPC → PC=0x00.
  - ret+IncPC+con_out together with a non-empty RAS → the ret wins.
- Build without `PC_RAS_EN`: call+con_out → PC=MuxOut, ret alone → hold, RAS outputs constant 1/0/0/0.
